// File: rtl/addsub_pkg.sv
// Shared types for the add/sub issue sequencer: opcodes and the buffered command record.
package addsub_pkg;

    // Data width that the command record is built for.
    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        OP_ADD      = 2'd0,
        OP_SUB      = 2'd1,
        OP_ACC_ADD  = 2'd2,
        OP_ACC_LOAD = 2'd3
    } op_t;

    typedef struct packed {
        op_t                     op;
        logic [DefaultWidth-1:0] a;
        logic [DefaultWidth-1:0] b;
    } cmd_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational adder/subtractor: add gives carry-out, subtract gives unsigned borrow.
module addsub_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,   // 0 = add, 1 = subtract
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    // Two's-complement subtract as a + ~b + 1; borrow is the inverted carry-out.
    always_comb begin
        b_eff   = mode_i ? ~b_i : b_i;
        full    = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, mode_i};
        sum_o   = full[WIDTH-1:0];
        carry_o = mode_i ? ~full[WIDTH] : full[WIDTH];
    end

endmodule

// File: rtl/addsub_issue_seq.sv
// Command FIFO in front of the add/sub core, with a held result stage and running accumulator.
module addsub_issue_seq
    import addsub_pkg::*;
#(
    // Must match DefaultWidth: FIFO entries are stored as cmd_t.
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic                   out_carry,
    output logic [1:0]             out_op,
    output logic [WIDTH-1:0]       acc_value,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    cmd_t            mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_carry_q, out_carry_d;
    op_t              out_op_q, out_op_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             push, pop;
    cmd_t             head;
    logic [WIDTH-1:0] core_a, core_sum, res_sum;
    logic             core_carry, res_carry;

    // Full FIFO refuses input even when it pops on the same edge.
    assign in_ready = (level_q != LvlW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (level_q != '0) && (!out_valid_q || out_ready);
    assign head     = mem_q[rd_ptr_q];

    // Accumulating adds take the running accumulator in place of operand A.
    assign core_a = (head.op == OP_ACC_ADD) ? acc_q : head.a;

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i     (core_a),
        .b_i     (head.b),
        .mode_i  (head.op == OP_SUB),
        .sum_o   (core_sum),
        .carry_o (core_carry)
    );

    // Select the issued result; a load bypasses the core.
    always_comb begin
        res_sum   = core_sum;
        res_carry = core_carry;
        if (head.op == OP_ACC_LOAD) begin
            res_sum   = head.a;
            res_carry = 1'b0;
        end
    end

    // Next-state for FIFO pointers, occupancy, output stage and accumulator.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_op_d    = out_op_q;
        acc_d       = acc_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase

        if (pop) begin
            out_valid_d = 1'b1;
            out_sum_d   = res_sum;
            out_carry_d = res_carry;
            out_op_d    = head.op;
            if (head.op == OP_ACC_ADD || head.op == OP_ACC_LOAD) begin
                acc_d = res_sum;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_op_q    <= OP_ADD;
            acc_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_op_q    <= out_op_d;
            acc_q       <= acc_d;
        end
    end

    // FIFO storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: op_t'(in_op), a: in_a, b: in_b};
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_op    = out_op_q;
    assign acc_value = acc_q;
    assign level     = level_q;

endmodule

// File: tb/tb_addsub_issue_seq.sv
// Self-checking bench for addsub_issue_seq: vector table, scoreboard and corner sequences.
module tb_addsub_issue_seq;
    import addsub_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_carry;
    logic [1:0] out_op;
    logic [3:0] acc_value;
    logic [2:0] level;

    addsub_issue_seq #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_op    (out_op),
        .acc_value (acc_value),
        .level     (level)
    );

    typedef struct packed {
        op_t        op;
        logic       carry;
        logic [3:0] sum;
        logic [3:0] acc;
    } exp_t;

    typedef struct {
        op_t        op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic       carry;
        logic [3:0] acc;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         level_max = 0;
    int         out_cyc[$];
    exp_t       sb[$];
    exp_t       got_e;
    logic [3:0] acc_m = '0;
    vec_t       tbl[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (int'(level) > level_max) level_max = int'(level);
    end

    // Scoreboard: every result consumed by the sink is compared with the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            out_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got op=%0d sum=%0d carry=%0d acc=%0d, required none",
                         out_op, out_sum, out_carry, acc_value);
            end else begin
                got_e = sb.pop_front();
                if ({out_op, out_carry, out_sum, acc_value} !==
                    {got_e.op, got_e.carry, got_e.sum, got_e.acc}) begin
                    bad++;
                    $display("FAIL result: got op=%0d sum=%0d carry=%0d acc=%0d, required op=%0d sum=%0d carry=%0d acc=%0d",
                             out_op, out_sum, out_carry, acc_value,
                             got_e.op, got_e.sum, got_e.carry, got_e.acc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic; tracks the accumulator in command order.
    function automatic exp_t model(input op_t op, input logic [3:0] a, input logic [3:0] b);
        exp_t       e;
        logic [4:0] t;
        e.op = op;
        case (op)
            OP_ADD: begin
                t       = {1'b0, a} + {1'b0, b};
                e.sum   = t[3:0];
                e.carry = t[4];
            end
            OP_SUB: begin
                e.sum   = a - b;
                e.carry = (a < b);
            end
            OP_ACC_ADD: begin
                t       = {1'b0, acc_m} + {1'b0, b};
                e.sum   = t[3:0];
                e.carry = t[4];
                acc_m   = t[3:0];
            end
            default: begin
                e.sum   = a;
                e.carry = 1'b0;
                acc_m   = a;
            end
        endcase
        e.acc = acc_m;
        return e;
    endfunction

    // Present a command, wait (bounded) for acceptance, record its expectation.
    task automatic send(input op_t op, input logic [3:0] a, input logic [3:0] b, input exp_t e);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0, required 1 within 20 cycles");
        end else begin
            sb.push_back(e);
            step();
        end
    endtask

    task automatic send_m(input op_t op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e = model(op, a, b);
        send(op, a, b, e);
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            step();
            n++;
        end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        tbl[0] = '{OP_ADD,      4'd9,  4'd8, 4'd1,  1'b1, 4'd0};
        tbl[1] = '{OP_ADD,      4'd3,  4'd4, 4'd7,  1'b0, 4'd0};
        tbl[2] = '{OP_SUB,      4'd3,  4'd5, 4'd14, 1'b1, 4'd0};
        tbl[3] = '{OP_SUB,      4'd5,  4'd3, 4'd2,  1'b0, 4'd0};
        tbl[4] = '{OP_SUB,      4'd7,  4'd7, 4'd0,  1'b0, 4'd0};
        tbl[5] = '{OP_ACC_LOAD, 4'd10, 4'd0, 4'd10, 1'b0, 4'd10};
        tbl[6] = '{OP_ACC_ADD,  4'd15, 4'd7, 4'd1,  1'b1, 4'd1};
        tbl[7] = '{OP_ACC_ADD,  4'd15, 4'd2, 4'd3,  1'b0, 4'd3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_out_op", out_op, 0);
        check("rst_acc", acc_value, 0);
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1);

        // Latency: accepted at edge E, visible after E+1
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = 4'd9;
        in_b     = 4'd8;
        sb.push_back(model(OP_ADD, 4'd9, 4'd8));
        step();
        in_valid = 1'b0;
        check("lat_valid_e", out_valid, 0);
        check("lat_level_e", level, 1);
        step();
        check("lat_valid_e1", out_valid, 1);
        check("lat_sum_e1", out_sum, 1);
        check("lat_carry_e1", out_carry, 1);
        check("lat_level_e1", level, 0);
        step();
        check("lat_drain_valid", out_valid, 0);

        // Vector table, issued back-to-back so ACC_ADDs chain
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.op    = tbl[i].op;
            e.carry = tbl[i].carry;
            e.sum   = tbl[i].sum;
            e.acc   = tbl[i].acc;
            send(tbl[i].op, tbl[i].a, tbl[i].b, e);
            acc_m = tbl[i].acc;
        end
        drain();

        // Backpressure: one held, four buffered, sixth stalled
        out_ready = 1'b0;
        send_m(OP_ADD, 4'd1, 4'd2);
        send_m(OP_SUB, 4'd4, 4'd9);
        send_m(OP_ACC_ADD, 4'd0, 4'd6);
        send_m(OP_ADD, 4'd15, 4'd15);
        send_m(OP_ACC_LOAD, 4'd12, 4'd0);
        in_valid = 1'b1;
        in_op    = OP_ACC_ADD;
        in_a     = 4'd0;
        in_b     = 4'd5;
        for (int i = 0; i < 3; i++) begin
            check("bp_level_full", level, 4);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold", {out_valid, out_op, out_carry, out_sum},
                  {1'b1, sb[0].op, sb[0].carry, sb[0].sum});
            step();
        end
        out_ready = 1'b1;
        send_m(OP_ACC_ADD, 4'd0, 4'd5);
        drain();

        // Streaming: eight results on eight consecutive cycles
        level_max = 0;
        out_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            send_m(op_t'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)));
        end
        drain();
        check("stream_level_max", level_max, 1);
        check("stream_count", out_cyc.size(), 8);
        if (out_cyc.size() == 8) check("stream_span", out_cyc[7] - out_cyc[0], 7);

        // Reset mid-stream with level=3, result held, acc=5
        out_ready = 1'b0;
        send_m(OP_ACC_LOAD, 4'd5, 4'd0);
        send_m(OP_ADD, 4'd1, 4'd1);
        send_m(OP_ADD, 4'd2, 4'd2);
        send_m(OP_SUB, 4'd3, 4'd1);
        in_valid = 1'b0;
        check("mid_level", level, 3);
        check("mid_out_valid", out_valid, 1);
        check("mid_acc", acc_value, 5);
        rst = 1'b1;
        sb.delete();
        acc_m = '0;
        step();
        rst = 1'b0;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_level", level, 0);
        check("mrst_acc", acc_value, 0);
        check("mrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("mrst_no_stale", out_valid, 0);
        check("mrst_level_after", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
